ssd_wta_select: RTL and testbench
=================================

SSD_WTA_SELECT -- requirements
Module: ssd_wta_select

Interface
REQ-001 SHALL have parameter SIZEIN, default 16, meaning pixel width of the upstream squarer; squared-difference input width is 2*SIZEIN+2.
REQ-002 SHALL have parameter WIN, default 9, meaning squared-difference samples summed per disparity candidate (WIN >= 2).
REQ-003 SHALL have parameter NUM_DISP, default 16, meaning disparity candidates per output pixel (NUM_DISP >= 2); DW = clog2(NUM_DISP).
REQ-004 SHALL have parameter ACCW, default 40, meaning accumulator and cost width (ACCW >= 2*SIZEIN+2).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ce  input  1  clock enable; when low, all registers hold.
REQ-008 sq_in  input  2*SIZEIN+2  squared difference from the upstream squarer.
REQ-009 sq_valid  input  1  sq_in carries a sample this cycle.
REQ-010 sq_sync  input  1  qualified by sq_valid; marks the sample as window index 0 of disparity 0.
REQ-011 disp_out  output  DW  winning disparity index.
REQ-012 cost_out  output  ACCW  winning window cost.
REQ-013 out_valid  output  1  disp_out/cost_out are a new result.

Function
REQ-014 A sample SHALL be accepted only in a cycle with ce=1 and sq_valid=1; other cycles SHALL leave counters, accumulator and best registers unchanged.
REQ-015 Accepted samples SHALL be in order: disparity d = 0..NUM_DISP-1, each with WIN consecutive samples k = 0..WIN-1.
REQ-016 The block SHALL have two states: IDLE and ACCUM.
REQ-017 IDLE: only an accepted sample with sq_sync=1 SHALL be processed, and it SHALL move the block to ACCUM as (d=0, k=0); accepted samples with sq_sync=0 SHALL be dropped.
REQ-018 ACCUM: an accepted sample with sq_sync=1 SHALL discard any partial result and restart at (d=0, k=0) using that sample, with no out_valid for the discarded pixel.
REQ-019 On k=0 the accumulator SHALL load the zero-extended sq_in; on k>0 it SHALL add sq_in, saturating at 2^ACCW-1.
REQ-020 On k=WIN-1 the completed cost C(d) SHALL be compared; if d=0 or C(d) < best_cost (strict), best_cost <= C(d) and best_disp <= d.
REQ-021 Ties SHALL keep the lower disparity.
REQ-022 k SHALL wrap from WIN-1 to 0 and increment d; d SHALL wrap from NUM_DISP-1 to 0. The state SHALL stay ACCUM, so back-to-back pixels need no new sync.
REQ-023 Completion of (d=NUM_DISP-1, k=WIN-1) in cycle T SHALL assert out_valid in cycle T+1, with disp_out/cost_out carrying the final winner including C(NUM_DISP-1).
REQ-024 out_valid SHALL be high for exactly one ce-enabled cycle per completed pixel; while ce=0 it SHALL hold its value, and consumers SHALL qualify it with ce.
REQ-025 disp_out/cost_out SHALL hold their last result until the next out_valid.
REQ-026 Best-cost registers SHALL NOT be visible on disp_out/cost_out mid-pixel.
REQ-027 Throughput SHALL be one sample per cycle with no bubbles.

Reset
REQ-028 When rst=1 in a cycle, the next state SHALL be IDLE with k=0, d=0, accumulator=0, best registers=0, disp_out=0, cost_out=0 and out_valid=0, regardless of ce or sq_valid.
REQ-029 Reset mid-pixel SHALL discard the partial result; no out_valid SHALL follow for it.

Verification (WIN=3, NUM_DISP=4, SIZEIN=16, ACCW=40)
REQ-030 Sync, then costs: d0 {5,5,5}, d1 {1,2,3}, d2 {9,0,0}, d3 {4,4,4} -> one out_valid pulse one cycle after the 12th sample, with disp_out=1 and cost_out=6.
REQ-031 Tie: every window sums to 7 -> disp_out=0, cost_out=7; with the minimum only at d3 (d3=2, others 7) -> disp_out=3, cost_out=2.
REQ-032 Samples before any sync, then sync mid-pixel after 5 samples, then 12 clean samples -> exactly one out_valid, reflecting only the post-resync 12 samples.
REQ-033 ce and sq_valid randomly deasserted (~30%) during a 3-pixel stream -> results identical to the unstalled run, one out_valid per pixel, outputs stable while ce=0.
REQ-034 Every sample = 2^34-1 with ACCW=35 -> cost_out=2^35-1 (saturated), disp_out=0; rst asserted at sample 7 of a pixel -> no out_valid, all outputs 0, IDLE until the next sync.

Source files
------------

// File: rtl/ssd_wta_select.sv
// ssd_wta_select: accumulates windowed squared differences per disparity and outputs the winner-take-all minimum.
module ssd_wta_select #(
    parameter int SIZEIN   = 16,
    parameter int WIN      = 9,
    parameter int NUM_DISP = 16,
    parameter int ACCW     = 40,
    localparam int SW      = 2*SIZEIN+2,
    localparam int DW      = $clog2(NUM_DISP),
    localparam int KW      = $clog2(WIN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [SW-1:0]   sq_in,
    input  logic            sq_valid,
    input  logic            sq_sync,
    output logic [DW-1:0]   disp_out,
    output logic [ACCW-1:0] cost_out,
    output logic            out_valid
);
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t          state;
    logic [KW-1:0]   k, pk;
    logic [DW-1:0]   d, pd, best_disp, nb_disp;
    logic [ACCW-1:0] acc, best_cost, cost, nb_cost;
    logic [ACCW:0]   sum;
    logic            take, last_k, last_d, win;
    // A sync sample always restarts at (d=0, k=0), whatever the current position.
    always_comb begin
        take    = ce && sq_valid && (sq_sync || state == ACCUM);
        pk      = sq_sync ? '0 : k;
        pd      = sq_sync ? '0 : d;
        sum     = {1'b0, acc} + (ACCW+1)'(sq_in);
        cost    = (pk == '0) ? ACCW'(sq_in) : (sum[ACCW] ? '1 : sum[ACCW-1:0]);
        last_k  = pk == KW'(WIN-1);
        last_d  = pd == DW'(NUM_DISP-1);
        win     = (pd == '0) || (cost < best_cost);
        nb_cost = win ? cost : best_cost;
        nb_disp = win ? pd : best_disp;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            d         <= '0;
            acc       <= '0;
            best_cost <= '0;
            best_disp <= '0;
            disp_out  <= '0;
            cost_out  <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= take && last_k && last_d;
            if (take) begin
                state <= ACCUM;
                acc   <= cost;
                k     <= last_k ? '0 : pk + 1'b1;
                d     <= last_k ? (last_d ? '0 : pd + 1'b1) : pd;
                if (last_k) begin
                    best_cost <= nb_cost;
                    best_disp <= nb_disp;
                    if (last_d) begin
                        disp_out <= nb_disp;
                        cost_out <= nb_cost;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ssd_wta_select.sv
// tb_ssd_wta_select: directed checks of the SSD winner-take-all selector (WIN=3, NUM_DISP=4).
module tb_ssd_wta_select;
    logic        clk = 0, rst = 1, ce = 0, sq_valid = 0, sq_sync = 0;
    logic [33:0] sq_in = '0;
    logic [1:0]  disp_out, disp2;
    logic [39:0] cost_out;
    logic [34:0] cost2;
    logic        out_valid, valid2;
    int          n_chk = 0, n_pass = 0, viol = 0, qn;
    int unsigned px [3][12];
    int          qd[$], qc[$];
    logic        ce_e = 0, rst_e = 1;
    logic [42:0] prev;

    ssd_wta_select #(.SIZEIN(16), .WIN(3), .NUM_DISP(4), .ACCW(40)) dut (
        .clk(clk), .rst(rst), .ce(ce), .sq_in(sq_in), .sq_valid(sq_valid), .sq_sync(sq_sync),
        .disp_out(disp_out), .cost_out(cost_out), .out_valid(out_valid));
    ssd_wta_select #(.SIZEIN(16), .WIN(3), .NUM_DISP(4), .ACCW(35)) dut_sat (
        .clk(clk), .rst(rst), .ce(ce), .sq_in(sq_in), .sq_valid(sq_valid), .sq_sync(sq_sync),
        .disp_out(disp2), .cost_out(cost2), .out_valid(valid2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_e  <= ce;
        rst_e <= rst;
    end
    // Record each pulse once (qualified by ce) and flag any output change across a ce=0 edge.
    always @(negedge clk) begin
        if (out_valid && ce) begin
            qd.push_back(int'(disp_out));
            qc.push_back(int'(cost_out));
        end
        if (!ce_e && !rst_e && {out_valid, disp_out, cost_out} != prev) viol++;
        prev = {out_valid, disp_out, cost_out};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send(input logic [33:0] v, input logic s);
        ce = 1; sq_valid = 1; sq_in = v; sq_sync = s;
        @(posedge clk); #1;
        sq_valid = 0; sq_sync = 0;
    endtask

    task automatic pixel(input int p, input logic s, input int n0, input int n1);
        for (int i = n0; i < n1; i++) send(34'(px[p][i]), s && i == 0);
    endtask

    task automatic ssend(input logic [33:0] v, input logic s);
        int tries = 0;
        do begin
            ce = $urandom_range(9) >= 3; sq_valid = $urandom_range(9) >= 3;
            sq_in = v; sq_sync = s;
            @(posedge clk); #1;
            tries++;
        end while (!(ce && sq_valid) && tries < 60);
        if (tries >= 60) chk("stall_budget", 64'(tries), 0);
        ce = 1; sq_valid = 0; sq_sync = 0;
    endtask

    task automatic idle(input int n);
        ce = 1; sq_valid = 0; sq_sync = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        px = '{'{5,5,5, 1,2,3, 9,0,0, 4,4,4},
               '{7,0,0, 3,4,0, 1,1,5, 2,2,3},
               '{7,0,0, 0,7,0, 0,0,7, 1,1,0}};
        repeat (2) @(posedge clk);
        #1; rst = 0;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_disp", 64'(disp_out), 0);
        chk("rst_cost", 64'(cost_out), 0);

        pixel(0, 1, 0, 12);
        chk("basic_valid", 64'(out_valid), 1);
        chk("basic_disp", 64'(disp_out), 1);
        chk("basic_cost", 64'(cost_out), 6);
        idle(1);
        chk("pulse_width", 64'(out_valid), 0);
        chk("hold_disp", 64'(disp_out), 1);
        chk("hold_cost", 64'(cost_out), 6);

        pixel(1, 0, 0, 6);
        chk("mid_disp", 64'(disp_out), 1);
        chk("mid_cost", 64'(cost_out), 6);
        chk("mid_valid", 64'(out_valid), 0);
        pixel(1, 0, 6, 12);
        chk("tie_valid", 64'(out_valid), 1);
        chk("tie_disp", 64'(disp_out), 0);
        chk("tie_cost", 64'(cost_out), 7);
        pixel(2, 0, 0, 12);
        chk("last_valid", 64'(out_valid), 1);
        chk("last_disp", 64'(disp_out), 3);
        chk("last_cost", 64'(cost_out), 2);
        idle(1);

        rst = 1; idle(1); rst = 0;
        qn = qd.size();
        repeat (4) send(34'd1, 0);
        send(34'd0, 1);
        repeat (4) send(34'd0, 0);
        pixel(0, 1, 0, 12);
        idle(2);
        chk("resync_pulses", 64'(qd.size() - qn), 1);
        chk("resync_disp", 64'(qd[$]), 1);
        chk("resync_cost", 64'(qc[$]), 6);

        qn = qd.size();
        viol = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 12; i++) ssend(34'(px[p][i]), p == 0 && i == 0);
        idle(2);
        chk("stall_pulses", 64'(qd.size() - qn), 3);
        if (qd.size() - qn == 3) begin
            chk("stall_d0", 64'(qd[qn]), 1);
            chk("stall_c0", 64'(qc[qn]), 6);
            chk("stall_d1", 64'(qd[qn+1]), 0);
            chk("stall_c1", 64'(qc[qn+1]), 7);
            chk("stall_d2", 64'(qd[qn+2]), 3);
            chk("stall_c2", 64'(qc[qn+2]), 2);
        end
        chk("stall_hold", 64'(viol), 0);

        pixel(1, 1, 0, 6);
        rst = 1; send(34'd5, 0); rst = 0;
        chk("rstmid_valid", 64'(out_valid), 0);
        chk("rstmid_disp", 64'(disp_out), 0);
        chk("rstmid_cost", 64'(cost_out), 0);
        qn = qd.size();
        repeat (12) send(34'd1, 0);
        idle(2);
        chk("idle_drop", 64'(qd.size() - qn), 0);
        chk("idle_cost", 64'(cost_out), 0);

        for (int i = 0; i < 12; i++) send('1, i == 0);
        chk("sat_valid", 64'(valid2), 1);
        chk("sat_cost", 64'(cost2), 64'h7_FFFF_FFFF);
        chk("sat_disp", 64'(disp2), 0);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
